// File: rtl/calc_entry_parser.sv
// Keypad command parser: builds decimal operands, hands each operation to the ALU
// over valid/ready, and chains every ALU result into the next source operand.
module calc_entry_parser #(
  parameter int unsigned W          = 16,
  parameter int unsigned MAX_DIGITS = 3,
  parameter int unsigned OP_N       = 3
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [4:0]      cmd,
  input  logic            cmd_valid,
  input  logic            req_ready,
  input  logic            res_valid,
  input  logic [W-1:0]    res_data,
  output logic [W-1:0]    src,
  output logic [W-1:0]    dst,
  output logic [OP_N-1:0] alu_op,
  output logic            req_valid,
  output logic [W-1:0]    entry,
  output logic [2:0]      digit_cnt,
  output logic            busy,
  output logic            rej
);

  localparam int unsigned XW       = W + 4;
  localparam logic [4:0]  CMD_OK   = 5'd15;
  localparam logic [4:0]  CMD_CLR  = 5'd16;
  localparam logic [4:0]  CMD_BKSP = 5'd17;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SRC  = 3'd1,
    S_OPER = 3'd2,
    S_DST  = 3'd3,
    S_WAIT = 3'd4,
    S_RES  = 3'd5
  } state_t;

  state_t          state;
  logic [W-1:0]    ans_q;

  logic            is_digit;
  logic            is_op;
  logic            dig_ok;
  logic [W-1:0]    digit;
  logic [W-1:0]    shrunk;
  logic [XW-1:0]   grown;
  logic [OP_N-1:0] op_code;

  // Command decode and the widened append; a digit is rejected if the
  // widened value spills above W bits or the entry is already full.
  always_comb begin
    is_digit = (cmd <= 5'd9);
    is_op    = (cmd >= 5'd10) && (cmd <= 5'd14);
    digit    = W'(cmd[3:0]);
    op_code  = OP_N'(cmd - 5'd10);
    grown    = XW'(entry) * XW'(10) + XW'(cmd[3:0]);
    shrunk   = entry / W'(10);
    dig_ok   = (digit_cnt < 3'(MAX_DIGITS)) && (grown[XW-1:W] == '0);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= S_IDLE;
      ans_q     <= '0;
      src       <= '0;
      dst       <= '0;
      alu_op    <= '0;
      req_valid <= 1'b0;
      entry     <= '0;
      digit_cnt <= '0;
      busy      <= 1'b0;
      rej       <= 1'b0;
    end else begin
      rej <= 1'b0;
      case (state)
        S_WAIT: begin
          rej <= cmd_valid;
          if (req_valid && req_ready) begin
            req_valid <= 1'b0;
            state     <= S_RES;
          end
        end
        S_RES: begin
          rej <= cmd_valid;
          if (res_valid) begin
            ans_q     <= res_data;
            src       <= res_data;
            entry     <= '0;
            digit_cnt <= '0;
            busy      <= 1'b0;
            state     <= S_OPER;
          end
        end
        default: if (cmd_valid) begin
          if (cmd == CMD_CLR) begin
            entry     <= '0;
            digit_cnt <= '0;
            state     <= S_IDLE;
          end else begin
            case (state)
              S_IDLE: begin
                if (is_digit) begin
                  entry     <= digit;
                  digit_cnt <= 3'd1;
                  state     <= S_SRC;
                end else if (is_op) begin
                  src    <= ans_q;
                  alu_op <= op_code;
                  state  <= S_OPER;
                end
              end
              S_SRC: begin
                if (is_digit) begin
                  if (dig_ok) begin
                    entry     <= grown[W-1:0];
                    digit_cnt <= digit_cnt + 3'd1;
                  end else begin
                    rej <= 1'b1;
                  end
                end else if (is_op) begin
                  src       <= entry;
                  alu_op    <= op_code;
                  entry     <= '0;
                  digit_cnt <= '0;
                  state     <= S_OPER;
                end else if (cmd == CMD_BKSP) begin
                  entry     <= shrunk;
                  digit_cnt <= digit_cnt - 3'd1;
                  if (digit_cnt == 3'd1) state <= S_IDLE;
                end
              end
              S_OPER: begin
                if (is_digit) begin
                  entry     <= digit;
                  digit_cnt <= 3'd1;
                  state     <= S_DST;
                end else if (is_op) begin
                  alu_op <= op_code;
                end
              end
              S_DST: begin
                if (is_digit) begin
                  if (dig_ok) begin
                    entry     <= grown[W-1:0];
                    digit_cnt <= digit_cnt + 3'd1;
                  end else begin
                    rej <= 1'b1;
                  end
                end else if (cmd == CMD_BKSP) begin
                  entry     <= shrunk;
                  digit_cnt <= digit_cnt - 3'd1;
                  if (digit_cnt == 3'd1) state <= S_OPER;
                end else if (cmd == CMD_OK) begin
                  dst       <= entry;
                  req_valid <= 1'b1;
                  busy      <= 1'b1;
                  state     <= S_WAIT;
                end
              end
              // Unused encodings fall back to idle on the next command.
              default: state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_entry_parser.sv
// Bench for calc_entry_parser: directed vector table, hand-written corner sequences,
// and random commands checked against a digit-list reference model.
module tb_calc_entry_parser;

  localparam int W    = 16;
  localparam int MAXD = 3;
  localparam int WMAX = (1 << W) - 1;

  logic         Clock = 1'b0;
  logic         Reset;
  logic [4:0]   cmd;
  logic         cmd_valid;
  logic         req_ready;
  logic         res_valid;
  logic [W-1:0] res_data;
  logic [W-1:0] src, dst, entry;
  logic [2:0]   alu_op, digit_cnt;
  logic         req_valid, busy, rej;

  logic [4:0]   cmd5;
  logic         cv5;
  logic [W-1:0] src5, dst5, entry5;
  logic [2:0]   op5, cnt5;
  logic         reqv5, busy5, rej5;

  int n_cmp = 0;
  int n_fail = 0;

  calc_entry_parser #(.W(W), .MAX_DIGITS(MAXD), .OP_N(3)) u_dut (
    .Clock(Clock), .Reset(Reset), .cmd(cmd), .cmd_valid(cmd_valid),
    .req_ready(req_ready), .res_valid(res_valid), .res_data(res_data),
    .src(src), .dst(dst), .alu_op(alu_op), .req_valid(req_valid),
    .entry(entry), .digit_cnt(digit_cnt), .busy(busy), .rej(rej)
  );

  calc_entry_parser #(.W(W), .MAX_DIGITS(5), .OP_N(3)) u_dut5 (
    .Clock(Clock), .Reset(Reset), .cmd(cmd5), .cmd_valid(cv5),
    .req_ready(req_ready), .res_valid(res_valid), .res_data(res_data),
    .src(src5), .dst(dst5), .alu_op(op5), .req_valid(reqv5),
    .entry(entry5), .digit_cnt(cnt5), .busy(busy5), .rej(rej5)
  );

  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int e_entry, input int e_cnt, input int e_rej,
                         input int e_reqv, input int e_busy, input int e_src, input int e_dst,
                         input int e_op);
    chk({tag, ".entry"}, 32'(entry), e_entry);
    chk({tag, ".cnt"},   32'(digit_cnt), e_cnt);
    chk({tag, ".rej"},   32'(rej), e_rej);
    chk({tag, ".reqv"},  32'(req_valid), e_reqv);
    chk({tag, ".busy"},  32'(busy), e_busy);
    chk({tag, ".src"},   32'(src), e_src);
    chk({tag, ".dst"},   32'(dst), e_dst);
    chk({tag, ".op"},    32'(alu_op), e_op);
  endtask

  // Drive one cycle of inputs, then sample just after the active edge.
  task automatic cyc(input int c, input int cv, input int rr, input int rv, input int rd);
    cmd       = 5'(c);
    cmd_valid = 1'(cv);
    req_ready = 1'(rr);
    res_valid = 1'(rv);
    res_data  = W'(rd);
    @(posedge Clock);
    #1;
  endtask

  task automatic cyc5(input int c);
    cmd5 = 5'(c);
    cv5  = 1'b1;
    @(posedge Clock);
    #1;
    cv5  = 1'b0;
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    res_valid = 1'b0;
    req_ready = 1'b0;
    cv5       = 1'b0;
    Reset     = 1'b0;
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b1;
  endtask

  // Reference model: the operand is kept as the list of typed digits.
  typedef enum {P_IDLE, P_SRC, P_OPER, P_DST, P_WAIT, P_RES} phase_t;
  phase_t m_phase;
  int     digits[$];
  int     m_src, m_dst, m_op, m_ans, m_reqv, m_rej;

  function automatic int value_of();
    int v = 0;
    foreach (digits[i]) v = v * 10 + digits[i];
    return v;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE;
    digits.delete();
    m_src = 0; m_dst = 0; m_op = 0; m_ans = 0; m_reqv = 0; m_rej = 0;
  endtask

  task automatic model_step(input int c, input int cv, input int rr, input int rv, input int rd);
    int v;
    v = value_of();
    m_rej = 0;
    if (m_phase == P_WAIT || m_phase == P_RES) begin
      if (cv != 0) m_rej = 1;
      if (m_phase == P_WAIT && rr != 0) begin
        m_reqv  = 0;
        m_phase = P_RES;
      end else if (m_phase == P_RES && rv != 0) begin
        m_ans = rd;
        m_src = rd;
        digits.delete();
        m_phase = P_OPER;
      end
    end else if (cv != 0) begin
      if (c == 16) begin
        digits.delete();
        m_phase = P_IDLE;
      end else if (c <= 9) begin
        if (m_phase == P_IDLE || m_phase == P_OPER) begin
          digits.delete();
          digits.push_back(c);
          if (m_phase == P_IDLE) m_phase = P_SRC;
          else m_phase = P_DST;
        end else if (digits.size() < MAXD && v * 10 + c <= WMAX) begin
          digits.push_back(c);
        end else begin
          m_rej = 1;
        end
      end else if (c <= 14) begin
        if (m_phase == P_IDLE) begin
          m_src = m_ans; m_op = c - 10; m_phase = P_OPER;
        end else if (m_phase == P_SRC) begin
          m_src = v; m_op = c - 10; digits.delete(); m_phase = P_OPER;
        end else if (m_phase == P_OPER) begin
          m_op = c - 10;
        end
      end else if (c == 15) begin
        if (m_phase == P_DST) begin
          m_dst = v; m_reqv = 1; m_phase = P_WAIT;
        end
      end else if (c == 17) begin
        if (m_phase == P_SRC || m_phase == P_DST) begin
          void'(digits.pop_back());
          if (digits.size() == 0) begin
            if (m_phase == P_SRC) m_phase = P_IDLE;
            else m_phase = P_OPER;
          end
        end
      end
    end
  endtask

  typedef struct {
    int cmd, cv, rv, rd;
    int entry, cnt, rej, reqv, busy, src, dst, op;
  } vec_t;

  localparam int NV = 32;
  vec_t tbl[NV];

  int rej_seen, reqv_drop, keep_bad;

  initial begin
    //        cmd cv rv rd   entry cnt rej reqv busy src dst op
    tbl[0]  = '{1,  1, 0, 0,   1,   1, 0, 0, 0,   0,   0, 0};
    tbl[1]  = '{2,  1, 0, 0,   12,  2, 0, 0, 0,   0,   0, 0};
    tbl[2]  = '{3,  1, 0, 0,   123, 3, 0, 0, 0,   0,   0, 0};
    tbl[3]  = '{10, 1, 0, 0,   0,   0, 0, 0, 0,   123, 0, 0};
    tbl[4]  = '{4,  1, 0, 0,   4,   1, 0, 0, 0,   123, 0, 0};
    tbl[5]  = '{5,  1, 0, 0,   45,  2, 0, 0, 0,   123, 0, 0};
    tbl[6]  = '{15, 1, 0, 0,   45,  2, 0, 1, 1,   123, 45, 0};
    tbl[7]  = '{0,  0, 0, 0,   45,  2, 0, 0, 1,   123, 45, 0};
    tbl[8]  = '{0,  0, 1, 168, 0,   0, 0, 0, 0,   168, 45, 0};
    tbl[9]  = '{11, 1, 0, 0,   0,   0, 0, 0, 0,   168, 45, 1};
    tbl[10] = '{8,  1, 0, 0,   8,   1, 0, 0, 0,   168, 45, 1};
    tbl[11] = '{15, 1, 0, 0,   8,   1, 0, 1, 1,   168, 8, 1};
    tbl[12] = '{0,  0, 0, 0,   8,   1, 0, 0, 1,   168, 8, 1};
    tbl[13] = '{0,  0, 1, 100, 0,   0, 0, 0, 0,   100, 8, 1};
    tbl[14] = '{16, 1, 0, 0,   0,   0, 0, 0, 0,   100, 8, 1};
    tbl[15] = '{9,  1, 0, 0,   9,   1, 0, 0, 0,   100, 8, 1};
    tbl[16] = '{9,  1, 0, 0,   99,  2, 0, 0, 0,   100, 8, 1};
    tbl[17] = '{9,  1, 0, 0,   999, 3, 0, 0, 0,   100, 8, 1};
    tbl[18] = '{9,  1, 0, 0,   999, 3, 1, 0, 0,   100, 8, 1};
    tbl[19] = '{0,  0, 0, 0,   999, 3, 0, 0, 0,   100, 8, 1};
    tbl[20] = '{16, 1, 0, 0,   0,   0, 0, 0, 0,   100, 8, 1};
    tbl[21] = '{4,  1, 0, 0,   4,   1, 0, 0, 0,   100, 8, 1};
    tbl[22] = '{7,  1, 0, 0,   47,  2, 0, 0, 0,   100, 8, 1};
    tbl[23] = '{17, 1, 0, 0,   4,   1, 0, 0, 0,   100, 8, 1};
    tbl[24] = '{17, 1, 0, 0,   0,   0, 0, 0, 0,   100, 8, 1};
    tbl[25] = '{17, 1, 0, 0,   0,   0, 0, 0, 0,   100, 8, 1};
    tbl[26] = '{10, 1, 0, 0,   0,   0, 0, 0, 0,   100, 8, 0};
    tbl[27] = '{5,  1, 0, 0,   5,   1, 0, 0, 0,   100, 8, 0};
    tbl[28] = '{17, 1, 0, 0,   0,   0, 0, 0, 0,   100, 8, 0};
    tbl[29] = '{7,  1, 0, 0,   7,   1, 0, 0, 0,   100, 8, 0};
    tbl[30] = '{20, 1, 0, 0,   7,   1, 0, 0, 0,   100, 8, 0};
    tbl[31] = '{12, 1, 0, 0,   7,   1, 0, 0, 0,   100, 8, 0};

    cmd = '0; res_data = '0; cmd5 = '0;
    do_reset();
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < NV; i++) begin
      cyc(tbl[i].cmd, tbl[i].cv, 1, tbl[i].rv, tbl[i].rd);
      chk_all($sformatf("vec%0d", i), tbl[i].entry, tbl[i].cnt, tbl[i].rej, tbl[i].reqv,
              tbl[i].busy, tbl[i].src, tbl[i].dst, tbl[i].op);
    end

    // ALU stalls: commands are dropped and operands held until the handshake.
    cyc(15, 1, 0, 0, 0);
    chk("stall.reqv", 32'(req_valid), 1);
    chk("stall.dst", 32'(dst), 7);
    chk("stall.busy", 32'(busy), 1);
    rej_seen = 0; reqv_drop = 0; keep_bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 2) cyc(3, 1, 0, 0, 0);
      else if (k == 5) cyc(16, 1, 0, 0, 0);
      else cyc(0, 0, 0, 0, 0);
      rej_seen += int'(rej);
      if (!req_valid) reqv_drop++;
      if (src != 100 || dst != 7 || entry != 7) keep_bad++;
    end
    chk("stall.rej_pulses", 32'(rej_seen), 2);
    chk("stall.reqv_drops", 32'(reqv_drop), 0);
    chk("stall.operands", 32'(keep_bad), 0);
    cyc(0, 0, 1, 0, 0);
    chk("hs.reqv", 32'(req_valid), 0);
    chk("hs.busy", 32'(busy), 1);
    cyc(4, 1, 1, 1, 55);
    chk("res_cmd.src", 32'(src), 55);
    chk("res_cmd.rej", 32'(rej), 1);
    chk("res_cmd.busy", 32'(busy), 0);
    chk("res_cmd.entry", 32'(entry), 0);
    cyc(0, 0, 1, 0, 0);
    chk("res_cmd.rej_end", 32'(rej), 0);
    cyc(3, 1, 1, 0, 0);
    chk("chain.entry", 32'(entry), 3);
    chk("chain.cnt", 32'(digit_cnt), 1);

    // Asynchronous reset while a request is pending.
    cyc(15, 1, 0, 0, 0);
    chk("pre_rst.reqv", 32'(req_valid), 1);
    #2;
    cmd_valid = 1'b0;
    Reset = 1'b0;
    #1;
    chk("async_rst.reqv", 32'(req_valid), 0);
    chk("async_rst.src", 32'(src), 0);
    chk("async_rst.dst", 32'(dst), 0);
    chk("async_rst.busy", 32'(busy), 0);
    @(posedge Clock);
    #1 Reset = 1'b1;
    cyc(10, 1, 0, 0, 0);
    cyc(2, 1, 0, 0, 0);
    cyc(15, 1, 0, 0, 0);
    chk("post_rst.src", 32'(src), 0);
    chk("post_rst.dst", 32'(dst), 2);
    chk("post_rst.reqv", 32'(req_valid), 1);
    chk("post_rst.op", 32'(alu_op), 0);
    cyc(0, 0, 1, 0, 0);
    chk("post_rst.hs", 32'(req_valid), 0);

    // Five-digit instance: the overflow check rejects 65536.
    cmd_valid = 1'b0;
    res_valid = 1'b0;
    cyc5(6); cyc5(5); cyc5(5); cyc5(3);
    chk("d5.entry4", 32'(entry5), 6553);
    chk("d5.cnt4", 32'(cnt5), 4);
    chk("d5.rej4", 32'(rej5), 0);
    cyc5(6);
    chk("d5.entry5", 32'(entry5), 6553);
    chk("d5.cnt5", 32'(cnt5), 4);
    chk("d5.rej5", 32'(rej5), 1);
    @(posedge Clock); #1;
    chk("d5.rej_end", 32'(rej5), 0);
    chk("d5.idle", 32'({reqv5, busy5, op5, src5, dst5}), 0);

    // Random commands against the reference model.
    do_reset();
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      int r, c, cv, rr, rv, rd;
      r = int'($urandom_range(0, 99));
      if (r < 45)      c = int'($urandom_range(0, 9));
      else if (r < 65) c = int'($urandom_range(10, 14));
      else if (r < 73) c = 15;
      else if (r < 77) c = 16;
      else if (r < 90) c = 17;
      else             c = int'($urandom_range(18, 31));
      cv = ($urandom_range(0, 3) != 0) ? 1 : 0;
      rr = int'($urandom_range(0, 1));
      rv = ($urandom_range(0, 3) == 0) ? 1 : 0;
      rd = int'($urandom_range(0, WMAX));
      model_step(c, cv, rr, rv, rd);
      cyc(c, cv, rr, rv, rd);
      chk_all($sformatf("rnd%0d", i), value_of(), digits.size(), m_rej, m_reqv,
              (m_phase == P_WAIT || m_phase == P_RES) ? 1 : 0, m_src, m_dst, m_op);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_entry_parser.md
Name: calc_entry_parser

Overview:
- Parametrised command-to-operand parser for the calculator datapath. Sits between the keypad encoder and the ALU.
- Accumulates decimal operands of configurable width and digit count, with backspace, clear, and overflow rejection.
- Issues each operation to the ALU over a valid/ready handshake, then waits for the ALU result.
- Feeds each ALU result back in as the source operand of the next operation (answer chaining).

Parameters:
W, 16, operand/result width in bits
MAX_DIGITS, 3, maximum decimal digits per operand (1..5 when W=16)
OP_N, 3, width of alu_op

Ports:
Clock  in  1  system clock
Reset  in  1  asynchronous, active-low reset
cmd  in  5  command code: 0-9 digit; 10 ADD, 11 SUB, 12 AND, 13 OR, 14 LSH; 15 OK; 16 CLR; 17 BKSP; 18-31 ignored
cmd_valid  in  1  one-cycle strobe qualifying cmd
req_ready  in  1  ALU accepts request
res_valid  in  1  one-cycle strobe, ALU result present
res_data  in  W  ALU result
src  out  W  source operand (registered)
dst  out  W  destination operand (registered)
alu_op  out  OP_N  operation code, 0..4 = ADD, SUB, AND, OR, LSH
req_valid  out  1  request pending to ALU
entry  out  W  operand currently being typed (display)
digit_cnt  out  3  digits in entry
busy  out  1  high in S_WAIT/S_RES; commands are dropped
rej  out  1  one-cycle pulse: digit rejected, or command dropped while busy

Behaviour:
- Reset values: all registers 0, alu_op=ADD, state S_IDLE.
  - Reset takes effect asynchronously, including mid-handshake; req_valid drops immediately.
- ans_q: internal register, reset 0, loaded with res_data on res_valid.
- All updates happen on the clock edge with cmd_valid=1; commands with cmd_valid=0 are ignored.
- Digit acceptance (S_SRC/S_DST):
  - Accept if digit_cnt<MAX_DIGITS and entry*10+d <= 2^W-1; compute in W+4 bits.
  - On accept: entry<=entry*10+d, digit_cnt+1.
  - On reject: entry unchanged, rej pulses the next cycle.
- BKSP: entry<=entry/10 (truncating), digit_cnt-1.
- CLR, in any state except S_WAIT/S_RES: entry=0, digit_cnt=0, next state S_IDLE. src, dst and ans_q are kept.
- States and transitions:
  - S_IDLE:
    - digit d -> entry=d, cnt=1, S_SRC
    - op -> src<=ans_q, alu_op<=op, S_OPER
    - OK/BKSP ignored
  - S_SRC:
    - digit -> accept/reject
    - op -> src<=entry, alu_op<=op, entry=0, cnt=0, S_OPER
    - BKSP -> if cnt==1 go to S_IDLE (entry=0); else shift
    - OK ignored
  - S_OPER:
    - digit d -> entry=d, cnt=1, S_DST
    - op -> alu_op<=op (last op wins), stay
    - OK/BKSP ignored
  - S_DST:
    - digit -> accept/reject
    - BKSP -> if cnt==1 go to S_OPER (entry=0); else shift
    - OK -> dst<=entry, req_valid<=1, S_WAIT
    - op ignored
  - S_WAIT:
    - req_valid held high; src/dst/alu_op stable
    - req_valid&req_ready -> req_valid<=0, S_RES; can occur in the same cycle req_valid first asserts to the ALU
  - S_RES:
    - res_valid -> ans_q<=res_data, src<=res_data, entry=0, cnt=0, S_OPER (chain)
    - a res_valid arriving in S_WAIT is ignored
- busy = state is S_WAIT or S_RES. A cmd_valid while busy is dropped and pulses rej.
- Simultaneous events:
  - res_valid and cmd_valid in the same S_RES cycle: the result is taken, the command is dropped and pulses rej.
  - CLR while busy: dropped.
- Latency: one command per cycle, back-to-back strobes allowed. Outputs are valid the cycle after the edge.
- Width rules: digit d is zero-extended; the multiply never wraps because overflowing digits are rejected.

Test Plan:
- Reset, then keys 1,2,3,ADD,4,5,OK with req_ready=1 -> src=123, dst=45, alu_op=0; req_valid high exactly 1 cycle; busy=1.
- From S_RES, res_valid with res_data=168, then SUB,8,OK -> src=168, alu_op=1, dst=8, request issued (chaining).
- MAX_DIGITS=3: keys 9,9,9,9 -> entry=999, rej pulses once. With MAX_DIGITS=5, W=16: 6,5,5,3,6 -> 4th digit accepted (6553), 5th rejected (65536 > 65535), rej=1.
- Keys 4,7,BKSP,BKSP,BKSP -> entry 47->4->0, state S_IDLE after the 2nd BKSP; 3rd BKSP ignored, rej=0. In S_DST: 5,BKSP -> back to S_OPER.
- req_ready held 0 for 10 cycles after OK; press 3 and CLR meanwhile -> req_valid stays high, src/dst unchanged, rej pulses twice; req_ready=1 -> handshake completes.
- Assert Reset in S_WAIT -> req_valid=0 and src=dst=0 immediately (asynchronous); after release, ADD,2,OK -> src=0 (ans_q cleared), dst=2.
